// File: rtl/modmul_reduce_driver.sv
// modmul_reduce_driver: initiator for the Barrett reduction core.
// Captures (a, b, Q), forms the full product, issues it to the reduction core
// with a one-cycle start pulse, waits for done and returns the result over a
// valid/ready output. One transaction in flight at a time.
// Optional feature macro: MODMUL_TIMEOUT_EN adds a WAIT-state watchdog that
// sets a sticky err flag and drops the transaction after TIMEOUT_CYCLES.
module modmul_reduce_driver #(
    parameter int unsigned DATA_WIDTH     = 48,
    parameter int unsigned Q_WIDTH        = 23,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Q_WIDTH-1:0]    a_in,
    input  logic [Q_WIDTH-1:0]    b_in,
    input  logic [Q_WIDTH-1:0]    q_in,
    output logic                  red_start,
    output logic [DATA_WIDTH-1:0] red_data_in,
    output logic [Q_WIDTH-1:0]    red_q,
    input  logic                  red_done,
    input  logic [Q_WIDTH-1:0]    red_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_WIDTH-1:0]    res_out,
    output logic                  busy,
    output logic                  err
);

    // The product must never be truncated on its way to the reduction core.
    if (DATA_WIDTH < 2 * Q_WIDTH) begin : g_width_check
        $error("modmul_reduce_driver: DATA_WIDTH must be >= 2*Q_WIDTH");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("modmul_reduce_driver: TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StMul, StIssue, StWait, StHold} state_e;

    state_e                   state_q, state_d;
    logic [Q_WIDTH-1:0]       a_q, b_q, q_q;
    logic [2*Q_WIDTH-1:0]     product;
    logic                     timeout;

    assign product = {{Q_WIDTH{1'b0}}, a_q} * {{Q_WIDTH{1'b0}}, b_q};

`ifdef MODMUL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;

    // Watchdog: held at zero outside WAIT so it starts from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != StWait) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Fires in the last allowed WAIT cycle; red_done still takes precedence.
    assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMul;
            StMul:   state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (red_done) begin
                    state_d = StHold;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs and operand/result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            red_start   <= 1'b0;
            out_valid   <= 1'b0;
            red_data_in <= '0;
            red_q       <= '0;
            res_out     <= '0;
            err         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            q_q         <= '0;
        end else begin
            // Status flags are decoded from the state being entered so they
            // line up with that state without a combinational path.
            in_ready  <= (state_d == StIdle);
            busy      <= (state_d != StIdle);
            red_start <= (state_d == StIssue);
            out_valid <= (state_d == StHold);
            if (state_q == StIdle && in_valid) begin
                a_q <= a_in;
                b_q <= b_in;
                q_q <= q_in;
            end
            // Loaded once per transaction, so stable from ISSUE through done.
            if (state_q == StMul) begin
                red_data_in <= DATA_WIDTH'(product);
                red_q       <= q_q;
            end
            if (state_q == StWait && red_done) begin
                res_out <= red_data_out;
            end
            if (timeout && !red_done) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modmul_reduce_driver.sv
// Self-checking bench for modmul_reduce_driver: behavioural reducer, a
// timestamp-based transaction model, and a per-cycle compare process.
module tb_modmul_reduce_driver;

    localparam int QW = 23;
    localparam int DW = 48;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] a_in, b_in, q_in;
    logic          red_start;
    logic [DW-1:0] red_data_in;
    logic [QW-1:0] red_q;
    logic          red_done;
    logic [QW-1:0] red_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] res_out;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    modmul_reduce_driver #(
        .DATA_WIDTH    (DW),
        .Q_WIDTH       (QW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .q_in        (q_in),
        .red_start   (red_start),
        .red_data_in (red_data_in),
        .red_q       (red_q),
        .red_done    (red_done),
        .red_data_out(red_data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res_out     (res_out),
        .busy        (busy),
        .err         (err)
    );

    // Counters
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Transaction model: a transaction is in flight from acceptance until its
    // result handshake (or a drop); age counts clock edges since acceptance.
    bit              started  = 0;
    bit              inflight = 0;
    bit              got_done = 0;
    bit              err_m    = 0;
    int              age      = 0;
    longint unsigned ma, mb, mq;
    longint unsigned m_red_data = 0, m_red_q = 0, m_res = 0;

    // Behavioural reducer controls
    bit              red_en    = 1;
    int              red_delay = 1;
    int              spur_req  = 0;
    int              spur_seen = 0;
    bit              pend      = 0;
    int              pcnt      = 0;
    longint unsigned pdata     = 0;

    // Hand-computed pins
    bit              pin_en   = 0;
    longint unsigned pin_prod = 0;
    longint unsigned pin_res  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model update on each clock edge from the inputs the DUT sees.
    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            inflight   = 0;
            got_done   = 0;
            err_m      = 0;
            m_red_data = 0;
            m_red_q    = 0;
            m_res      = 0;
        end else if (!inflight) begin
            if (in_valid) begin
                inflight = 1;
                got_done = 0;
                age      = 0;
                ma       = a_in;
                mb       = b_in;
                mq       = q_in;
            end
        end else if (got_done) begin
            if (out_ready) begin
                inflight = 0;
                got_done = 0;
            end
        end else begin
            if (age == 0) begin
                m_red_data = ma * mb;
                m_red_q    = mq;
            end else if (age >= 2 && red_done) begin
                got_done = 1;
                m_res    = red_data_out;
            end
`ifdef MODMUL_TIMEOUT_EN
            else if (age - 1 == TO) begin
                inflight = 0;
                err_m    = 1;
            end
`endif
            age++;
        end
    end

    // Behavioural reduction core plus injectable spurious done pulses.
    always @(negedge clk) begin
        red_done     = 1'b0;
        red_data_out = QW'($urandom);
        if (pend) begin
            if (pcnt == 0) begin
                red_done     = 1'b1;
                red_data_out = QW'(pdata);
                pend         = 0;
            end else begin
                pcnt--;
            end
        end
        if (spur_req != spur_seen) begin
            spur_seen = spur_req;
            red_done  = 1'b1;
        end
        if (red_start === 1'b1 && red_en) begin
            pend  = 1;
            pcnt  = red_delay - 1;
            pdata = (red_q == 0) ? 0 : (64'(red_data_in) % 64'(red_q));
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(!inflight));
            chk("busy", 64'(busy), 64'(inflight));
            chk("red_start", 64'(red_start), 64'(inflight && !got_done && age == 1));
            chk("out_valid", 64'(out_valid), 64'(got_done));
            chk("res_out", 64'(res_out), m_res);
            chk("red_data_in", 64'(red_data_in), m_red_data);
            chk("red_q", 64'(red_q), m_red_q);
            chk("err", 64'(err), 64'(err_m));
            if (got_done && out_ready) begin
                chk("result", 64'(res_out), (ma * mb) % mq);
                if (pin_en) chk("pin_res", 64'(res_out), pin_res);
            end
            if (pin_en && inflight && !got_done && age == 1) begin
                chk("pin_prod", 64'(red_data_in), pin_prod);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair until accepted, then keep in_valid high with junk.
    task automatic accept(input longint unsigned a, input longint unsigned b,
                          input longint unsigned q);
        int n = 0;
        in_valid = 1'b1;
        a_in     = QW'(a);
        b_in     = QW'(b);
        q_in     = QW'(q);
        while (in_ready !== 1'b1) begin
            step();
            n++;
            if (n > 100) begin
                $display("FAIL accept_wait: got in_ready=%b, expected 1 within 100 cycles", in_ready);
                $fatal(1);
            end
        end
        step();
        a_in = QW'($urandom);
        b_in = QW'($urandom);
        q_in = QW'($urandom);
    endtask

    // Wait for the result, apply backpressure, then take it.
    task automatic finish(input int hold, input bit spur);
        int n = 0;
        while (out_valid !== 1'b1) begin
            step();
            n++;
            if (n > 200) begin
                $display("FAIL result_wait: got out_valid=%b, expected 1 within 200 cycles", out_valid);
                $fatal(1);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (i == 0 && spur) spur_req++;
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic txn(input longint unsigned a, input longint unsigned b,
                       input longint unsigned q, input int dly, input int hold, input bit spur);
        red_delay = dly;
        accept(a, b, q);
        finish(hold, spur);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        q_in      = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Spurious done while idle
        spur_req++;
        repeat (3) step();

        // Small pinned case: 3*5 = 15, 15 mod 7 = 1
        pin_en = 1; pin_prod = 15; pin_res = 1;
        txn(3, 5, 7, 3, 0, 0);
        pin_en = 0;

        // (Q-1)^2 with Q = 8380417: product 0x3FE004000000, residue 1
        pin_en = 1; pin_prod = 64'h3FE0_0400_0000; pin_res = 1;
        txn(8380416, 8380416, 8380417, 1, 0, 0);
        pin_en = 0;

        // Five cycles of backpressure with a spurious done in HOLD
        txn(100, 200, 1009, 2, 5, 1);

        // Done arriving in the 15th WAIT cycle
        txn(1234, 5678, 7919, TO, 1, 0);

        // Reset during WAIT; the reducer's later done must be ignored
        red_delay = 6;
        accept(11, 12, 13);
        repeat (4) step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        pin_en = 1; pin_prod = 8; pin_res = 3;
        txn(2, 4, 5, 2, 0, 0);
        pin_en = 0;

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            longint unsigned q, a, b;
            int hold;
            q    = $urandom_range(8388607, 2);
            a    = $urandom % q;
            b    = $urandom % q;
            hold = $urandom_range(3, 0);
            txn(a, b, q, $urandom_range(10, 1), hold, (hold > 0) && ($urandom % 2 == 1));
        end

        // Reducer never answers
        red_en = 0;
        accept(5, 6, 11);
        in_valid = 1'b0;
`ifdef MODMUL_TIMEOUT_EN
        begin
            int n = 0;
            while (busy === 1'b1) begin
                step();
                n++;
                if (n > 40) begin
                    $display("FAIL timeout_wait: got busy=%b, expected 0 within 40 cycles", busy);
                    $fatal(1);
                end
            end
        end
        repeat (3) step();
        red_en = 1;
        txn(3, 3, 7, 2, 1, 0);
`else
        repeat (40) step();
        red_en = 1;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        txn(9, 9, 13, 3, 0, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
